// File: rtl/irq_prio_arbiter.sv
// ---------------------------------------------------------------------------
// irq_prio_arbiter
//
// Clocked interrupt priority arbiter. Request lines are latched into sticky
// pending bits, masked by a per-channel enable shared by every group, and
// arbitrated by fixed group priority (group 0 highest). Inside the winning
// group the channel is picked either by lowest index (RR=0) or round-robin
// from a per-group pointer (RR=1). One grant at a time is offered to the
// servicing sequencer over a valid/ready handshake.
//
// Parameters
//   NCH   channels per group (2..64)
//   NGRP  number of groups   (1..8)
//   RR    0 = fixed channel priority, 1 = round-robin within a group
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        request lines, bit g*NCH+c = group g, channel c
//   en         channel enable, shared by all groups
//   grant_vld  grant offer valid (flop)
//   grant_rdy  consumer accepts the offer
//   grant_grp  winning group index (flop)
//   grant_ch   winning channel index (flop)
//   grp_pend   per-group OR of pending & enable (combinational)
//   any_pend   OR of grp_pend (combinational)
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no offer outstanding; arbitrate eligible bits each cycle
//   ST_OFFER | grant held stable on grant_grp/grant_ch until grant_rdy
// ---------------------------------------------------------------------------
module irq_prio_arbiter #(
  parameter  int NCH  = 9,
  parameter  int NGRP = 3,
  parameter  int RR   = 0,
  localparam int CHW  = (NCH  > 2) ? $clog2(NCH)  : 1,
  localparam int GW   = (NGRP > 2) ? $clog2(NGRP) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NGRP*NCH-1:0]  req,
  input  logic [NCH-1:0]       en,
  output logic                 grant_vld,
  input  logic                 grant_rdy,
  output logic [GW-1:0]        grant_grp,
  output logic [CHW-1:0]       grant_ch,
  output logic [NGRP-1:0]      grp_pend,
  output logic                 any_pend
);

  if (NCH < 2 || NCH > 64) begin : g_bad_nch
    $error("irq_prio_arbiter: NCH must be in 2..64");
  end
  if (NGRP < 1 || NGRP > 8) begin : g_bad_ngrp
    $error("irq_prio_arbiter: NGRP must be in 1..8");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  state_e                     state_q;
  logic [NGRP*NCH-1:0]        pend_q;
  logic [NGRP*NCH-1:0]        pend_d;
  logic [NGRP-1:0][CHW-1:0]   ptr_q;
  logic                       grant_vld_q;
  logic [GW-1:0]              grant_grp_q;
  logic [CHW-1:0]             grant_ch_q;

  logic [NGRP*NCH-1:0]        elig;
  logic [NGRP-1:0]            grp_any;
  logic                       win_found;
  logic [GW-1:0]              win_grp;
  logic [NCH-1:0]             win_vec;
  logic [CHW-1:0]             win_ptr;
  logic [CHW-1:0]             fix_ch;
  logic [CHW-1:0]             rr_ch;
  logic [CHW-1:0]             win_ch;
  logic [CHW-1:0]             ptr_next;
  logic                       accept;
  logic [NGRP*NCH-1:0]        clr;

  // ---------------------------------------------------------------------
  // Eligibility and per-group summary
  // ---------------------------------------------------------------------
  assign elig = pend_q & {NGRP{en}};

  always_comb begin
    grp_any = '0;
    for (int g = 0; g < NGRP; g++) begin
      grp_any[g] = |elig[g*NCH +: NCH];
    end
  end

  assign win_found = |grp_any;

  // Scan from the top down so the lowest-numbered active group is the last
  // assignment and therefore the winner.
  always_comb begin
    win_grp = '0;
    for (int g = NGRP-1; g >= 0; g--) begin
      if (grp_any[g]) begin
        win_grp = GW'(g);
      end
    end
  end

  always_comb begin
    win_vec = '0;
    win_ptr = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (win_grp == GW'(g)) begin
        win_vec = elig[g*NCH +: NCH];
        win_ptr = ptr_q[g];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------------
  always_comb begin
    fix_ch = '0;
    for (int c = NCH-1; c >= 0; c--) begin
      if (win_vec[c]) begin
        fix_ch = CHW'(c);
      end
    end
  end

  // Rotate the winning group's vector so the pointer lands at bit 0; the
  // first set bit of the rotated vector is the offset from the pointer.
  always_comb begin : p_rr
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic             hit;
    int               s;
    dbl   = {win_vec, win_vec} >> win_ptr;
    rot   = dbl[NCH-1:0];
    hit   = 1'b0;
    s     = 0;
    rr_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        s   = int'(win_ptr) + k;
        if (s >= NCH) begin
          s = s - NCH;
        end
        rr_ch = CHW'(s);
      end
    end
  end

  assign win_ch = (RR != 0) ? rr_ch : fix_ch;

  // ---------------------------------------------------------------------
  // Accept and pending update (set wins over clear)
  // ---------------------------------------------------------------------
  assign accept = (state_q == ST_OFFER) && grant_rdy;

  always_comb begin
    clr = '0;
    for (int g = 0; g < NGRP; g++) begin
      for (int c = 0; c < NCH; c++) begin
        clr[g*NCH + c] = accept && (grant_grp_q == GW'(g)) && (grant_ch_q == CHW'(c));
      end
    end
  end

  assign pend_d   = (pend_q & ~clr) | req;
  assign ptr_next = (grant_ch_q == CHW'(NCH-1)) ? '0 : grant_ch_q + 1'b1;

  // ---------------------------------------------------------------------
  // State machine with registered grant outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      ptr_q       <= '0;
      grant_vld_q <= 1'b0;
      grant_grp_q <= '0;
      grant_ch_q  <= '0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_grp_q <= win_grp;
            grant_ch_q  <= win_ch;
            grant_vld_q <= 1'b1;
            state_q     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          // Offer is frozen here: enable, new requests and req falling do
          // not touch grant_grp_q/grant_ch_q until the consumer accepts.
          if (grant_rdy) begin
            grant_vld_q <= 1'b0;
            state_q     <= ST_IDLE;
            if (RR != 0) begin
              for (int g = 0; g < NGRP; g++) begin
                if (grant_grp_q == GW'(g)) begin
                  ptr_q[g] <= ptr_next;
                end
              end
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          grant_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_vld = grant_vld_q;
  assign grant_grp = grant_grp_q;
  assign grant_ch  = grant_ch_q;
  assign grp_pend  = grp_any;
  assign any_pend  = |grp_any;

endmodule

// File: tb/tb_irq_prio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irq_prio_arbiter
//
// Directed bench for irq_prio_arbiter. Three instances share clock and reset:
//   u_fix   defaults (NCH=9, NGRP=3, RR=0)
//   u_rr    NCH=9, NGRP=3, RR=1
//   u_small NCH=4, NGRP=5, RR=0
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_irq_prio_arbiter;

  logic clk;
  logic rst_n;

  // default instance
  logic [26:0] req_f;
  logic [8:0]  en_f;
  logic        rdy_f;
  logic        vld_f;
  logic [1:0]  grp_f;
  logic [3:0]  ch_f;
  logic [2:0]  gp_f;
  logic        ap_f;

  // round-robin instance
  logic [26:0] req_r;
  logic [8:0]  en_r;
  logic        rdy_r;
  logic        vld_r;
  logic [1:0]  grp_r;
  logic [3:0]  ch_r;
  logic [2:0]  gp_r;
  logic        ap_r;

  // small instance
  logic [19:0] req_s;
  logic [3:0]  en_s;
  logic        rdy_s;
  logic        vld_s;
  logic [2:0]  grp_s;
  logic [1:0]  ch_s;
  logic [4:0]  gp_s;
  logic        ap_s;

  int n_chk;
  int n_err;

  irq_prio_arbiter u_fix (
    .clk(clk), .rst_n(rst_n), .req(req_f), .en(en_f),
    .grant_vld(vld_f), .grant_rdy(rdy_f), .grant_grp(grp_f), .grant_ch(ch_f),
    .grp_pend(gp_f), .any_pend(ap_f)
  );

  irq_prio_arbiter #(.NCH(9), .NGRP(3), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r), .en(en_r),
    .grant_vld(vld_r), .grant_rdy(rdy_r), .grant_grp(grp_r), .grant_ch(ch_r),
    .grp_pend(gp_r), .any_pend(ap_r)
  );

  irq_prio_arbiter #(.NCH(4), .NGRP(5), .RR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .req(req_s), .en(en_s),
    .grant_vld(vld_s), .grant_rdy(rdy_s), .grant_grp(grp_s), .grant_ch(ch_s),
    .grp_pend(gp_s), .any_pend(ap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : p_main
    logic [3:0] rr_exp [4];
    rr_exp = '{4'd2, 4'd5, 4'd2, 4'd5};
    n_chk = 0;
    n_err = 0;

    // ---- reset with requests asserted ------------------------------------
    rst_n = 1'b0;
    req_f = '1; req_r = '1; req_s = '1;
    en_f  = '1; en_r  = '1; en_s  = '1;
    rdy_f = 1'b0; rdy_r = 1'b0; rdy_s = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_vld",  32'(vld_f), 32'd0);
      chk("rst_grp",  32'(grp_f), 32'd0);
      chk("rst_ch",   32'(ch_f),  32'd0);
      chk("rst_gpend",32'(gp_f),  32'd0);
      chk("rst_apend",32'(ap_f),  32'd0);
    end
    chk("rst_rr_vld",    32'(vld_r), 32'd0);
    chk("rst_small_gp",  32'(gp_s),  32'd0);
    req_f = '0; req_r = '0; req_s = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_rst_vld",  32'(vld_f), 32'd0);
      chk("post_rst_apend",32'(ap_f),  32'd0);
    end

    // ---- group priority: (2,4) and (0,7) --------------------------------
    en_f  = 9'h1FF;
    rdy_f = 1'b1;
    req_f = (27'd1 << 22) | (27'd1 << 7);
    tick();
    req_f = '0;
    chk("gp_pend0", 32'(gp_f),  32'b101);
    chk("gp_vld0",  32'(vld_f), 32'd0);
    tick();
    chk("gp_vld1",  32'(vld_f), 32'd1);
    chk("gp_grp1",  32'(grp_f), 32'd0);
    chk("gp_ch1",   32'(ch_f),  32'd7);
    chk("gp_pend1", 32'(gp_f),  32'b101);
    tick();
    chk("gp_gap",   32'(vld_f), 32'd0);
    chk("gp_pend2", 32'(gp_f),  32'b100);
    tick();
    chk("gp_vld2",  32'(vld_f), 32'd1);
    chk("gp_grp2",  32'(grp_f), 32'd2);
    chk("gp_ch2",   32'(ch_f),  32'd4);
    tick();
    chk("gp_vld3",  32'(vld_f), 32'd0);
    chk("gp_pend3", 32'(gp_f),  32'b000);
    tick();
    chk("gp_vld4",  32'(vld_f), 32'd0);

    // ---- masking of (1,0) ------------------------------------------------
    en_f  = 9'h1FE;
    req_f = 27'd1 << 9;
    tick();
    req_f = '0;
    chk("mask_gpend", 32'(gp_f),  32'd0);
    tick();
    chk("mask_vld",   32'(vld_f), 32'd0);
    en_f = 9'h1FF;
    #1;
    chk("unmask_gpend", 32'(gp_f), 32'b010);
    tick();
    chk("unmask_vld", 32'(vld_f), 32'd1);
    chk("unmask_grp", 32'(grp_f), 32'd1);
    chk("unmask_ch",  32'(ch_f),  32'd0);
    tick();
    chk("unmask_acc_vld", 32'(vld_f), 32'd0);
    chk("unmask_acc_ap",  32'(ap_f),  32'd0);

    // ---- stall and no retraction ----------------------------------------
    rdy_f = 1'b0;
    req_f = 27'd1 << 12;
    tick();
    req_f = '0;
    tick();
    chk("stall_vld0", 32'(vld_f), 32'd1);
    chk("stall_grp0", 32'(grp_f), 32'd1);
    chk("stall_ch0",  32'(ch_f),  32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        req_f = 27'd1;
        en_f  = 9'h1F7;
      end
      tick();
      req_f = '0;
      chk("stall_vld", 32'(vld_f), 32'd1);
      chk("stall_grp", 32'(grp_f), 32'd1);
      chk("stall_ch",  32'(ch_f),  32'd3);
    end
    rdy_f = 1'b1;
    tick();
    chk("stall_acc_vld", 32'(vld_f), 32'd0);
    tick();
    chk("stall_next_vld", 32'(vld_f), 32'd1);
    chk("stall_next_grp", 32'(grp_f), 32'd0);
    chk("stall_next_ch",  32'(ch_f),  32'd0);
    tick();
    chk("stall_next_acc", 32'(vld_f), 32'd0);
    en_f = 9'h1FF;
    tick();
    chk("stall_drained", 32'(ap_f), 32'd0);

    // ---- round-robin vs fixed with (0,2),(0,5) held ----------------------
    rdy_r = 1'b1;
    req_r = (27'd1 << 2) | (27'd1 << 5);
    req_f = (27'd1 << 2) | (27'd1 << 5);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_vld", 32'(vld_r), 32'd1);
      chk("rr_ch",  32'(ch_r),  32'(rr_exp[k]));
      chk("fix_vld",32'(vld_f), 32'd1);
      chk("fix_ch", 32'(ch_f),  32'd2);
      tick();
      chk("rr_bubble",  32'(vld_r), 32'd0);
      chk("fix_bubble", 32'(vld_f), 32'd0);
    end
    req_r = '0;
    req_f = '0;

    // ---- set wins on accept, pointer wrap --------------------------------
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(vld_r), 32'd0);
    tick();
    rst_n = 1'b1;
    req_r = 27'd1 << 8;
    tick();
    tick();
    chk("wrap_vld0", 32'(vld_r), 32'd1);
    chk("wrap_ch0",  32'(ch_r),  32'd8);
    tick();
    chk("wrap_bubble", 32'(vld_r), 32'd0);
    chk("wrap_still_pend", 32'(gp_r), 32'b001);
    req_r = (27'd1 << 8) | (27'd1 << 4);
    tick();
    chk("wrap_reoffer_vld", 32'(vld_r), 32'd1);
    chk("wrap_reoffer_ch",  32'(ch_r),  32'd8);
    tick();
    req_r = '0;
    chk("wrap_acc_vld", 32'(vld_r), 32'd0);
    tick();
    chk("wrap_ptr_vld", 32'(vld_r), 32'd1);
    chk("wrap_ptr_ch",  32'(ch_r),  32'd4);

    // ---- NCH=4, NGRP=5 build: request (4,3) ------------------------------
    req_s = 20'd1 << 19;
    tick();
    req_s = '0;
    chk("small_gpend", 32'(gp_s), 32'b10000);
    tick();
    chk("small_vld", 32'(vld_s), 32'd1);
    chk("small_grp", 32'(grp_s), 32'd4);
    chk("small_ch",  32'(ch_s),  32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_prio_arbiter.md
# irq_prio_arbiter

Parametrised, clocked successor to the combinational 27-channel (3 groups × 9 channels) priority interrupt decoder. It latches interrupt requests into sticky pending bits and gates them with a per-channel enable shared by all groups. It arbitrates by fixed group priority, with fixed or round-robin channel priority inside a group, and offers one grant at a time over a valid/ready handshake. It sits between peripheral request lines and the interrupt-servicing sequencer.

## Interface
- `NCH`, 9: channels per group; legal range 2..64.
- `NGRP`, 3: number of groups; legal range 1..8; group 0 has the highest priority.
- `RR`, 0: channel selection inside the winning group; 0 = fixed (lowest index wins), 1 = round-robin.
- Derived, not overridable: `CHW = max(1, clog2(NCH))`, `GW = max(1, clog2(NGRP))`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion is synchronised externally.
- `req`  in  NGRP*NCH  request lines; bit `g*NCH+c` is group g, channel c; level-sampled.
- `en`  in  NCH  channel enable, shared by all groups; 0 masks channel c in every group.
- `grant_vld`  out  1  grant offer valid.
- `grant_rdy`  in  1  consumer accepts the offer.
- `grant_grp`  out  GW  winning group index.
- `grant_ch`  out  CHW  winning channel index.
- `grp_pend`  out  NGRP  per-group OR of (pending & en); combinational from the pending register and `en`.
- `any_pend`  out  1  OR of `grp_pend`.

## Operation
- **Pending register** (`NGRP*NCH` bits). Each edge computes `pend <= (pend & ~clr) | req`.
  - `clr` is one-hot at the accepted grant bit, and only on an accept edge.
  - Set wins over clear: if `req` is high on the same bit at its accept edge, that bit stays pending.
- **Eligibility.** Bit `(g,c)` is eligible when `pend[g*NCH+c] & en[c]`.
- **Group selection.** The lowest g with any eligible bit wins.
- **Channel selection.**
  - RR=0: the lowest eligible c in the winning group.
  - RR=1: the first eligible c at or after `ptr[g]`, scanning upward and wrapping from NCH-1 to 0.
  - `ptr[g]` is per group, CHW bits wide, and resets to 0.
  - On accept, `ptr[g] <= (c == NCH-1) ? 0 : c+1`. Pointers of other groups are unchanged.
- **State machine.**
  - IDLE: if any bit is eligible, register `grant_grp`/`grant_ch` and go to OFFER. Otherwise stay.
  - OFFER: hold `grant_vld=1` with `grant_grp`/`grant_ch` stable until `grant_rdy`. On the accept edge, clear the bit, update `ptr` if RR=1, and return to IDLE.
- **No retraction.** An offer is never withdrawn or changed, even if `en[c]` drops, a higher-priority request arrives, or the bit's `req` falls.
- **No preemption.** A higher-priority request is served after the current accept.

## Timing
- **Reset values.**
  - `pend`=0, `ptr`=0, state IDLE.
  - `grant_vld`=0, `grant_grp`=0, `grant_ch`=0.
  - `grp_pend`=0 and `any_pend`=0, because `pend` is 0.
- **Request latency.** `req` sampled high at edge k gives `pend` set after k; `grp_pend` reflects it in the same cycle; `grant_vld` rises after edge k+1.
- **Accept.** Accept occurs at an edge where `grant_vld & grant_rdy`. `grant_vld` is 0 for at least one cycle after every accept (IDLE bubble). Maximum throughput is one grant per 2 cycles.
- **`grant_rdy` outside OFFER** is ignored.
- **`en` effect.** `en` changes affect `grp_pend` combinationally. They affect arbitration only in IDLE.
- **Reset mid-offer.** Asserting `rst_n` low clears everything asynchronously. The pending offer is lost.
- **Output stability.** All outputs except `grp_pend`/`any_pend` are driven from flops.

## Test plan
1. **Reset behaviour.** Drive `rst_n`=0 with `req` all ones for 3 cycles. Required: all outputs 0. Release reset with `req`=0 and `en`=all ones. Required: `grant_vld` stays 0 and `any_pend` stays 0.
2. **Group priority.** Defaults, `en`=0x1FF, pulse `req` bits (2,4) and (0,7) for one cycle, `grant_rdy`=1. Required grant sequence: grp 0/ch 7, then grp 2/ch 4. `grp_pend` goes 3'b101 → 3'b100 → 0. `grant_vld` is high exactly 2 cycles, separated by a 1-cycle gap.
3. **Masking.** `en`=0x1FE, `req` bit (1,0) pulsed. Required: `grp_pend`=0 and no grant. Then set `en`=0x1FF. Required: `grp_pend`=3'b010 in the same cycle, and a grant grp 1/ch 0 offered one edge later.
4. **Stall and no-retraction.** Offer grp 1/ch 3 with `grant_rdy`=0 for 5 cycles. Meanwhile pulse (0,0) and drop `en[3]`. Required: the offer stays grp 1/ch 3 for all 5 cycles. After `grant_rdy`, the next grant is grp 0/ch 0.
5. **Round-robin, RR=1.** Hold `req` bits (0,2) and (0,5) high continuously, `grant_rdy`=1. Required grant order: ch 2, 5, 2, 5. With RR=0 the same stimulus must give ch 2, 2, 2.
6. **Set wins and wrap.** RR=1: re-assert `req` (0,8) on its accept edge. Required: (0,8) is re-offered after the bubble, and `ptr[0]` wraps to 0. Then NCH=4, NGRP=5 build: request (4,3). Required: `grant_grp`=4, `grant_ch`=3.
